// File: rtl/corr_pkg.sv
// Shared correlator definitions: packet layout, sync byte and streamer FSM states.
// Byte 0 of every correlator packet carries the 8-bit window number.
package corr_pkg;

  localparam int          CORR_PKT_LEN   = 5;
  localparam logic [7:0]  CORR_SYNC_BYTE = 8'hA5;

  localparam int PKT_IDX_WINNUM  = 0;
  localparam int PKT_IDX_COUNTX  = 1;
  localparam int PKT_IDX_COUNTY  = 2;
  localparam int PKT_IDX_ISECT   = 3;
  localparam int PKT_IDX_SYMDIFF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BODY = 1'b1
  } strm_state_e;

endpackage

// File: rtl/corr_pkt_streamer.sv
// Pops correlator packets from the pkt FIFO and streams them (optionally sync-prefixed) as bytes;
// popped byte shows on o_txData next cycle, one-entry slot stalls on !i_txReady, 1 byte/cycle sustained.
module corr_pkt_streamer
  import corr_pkg::*;
#(
  parameter int         PKT_LEN   = CORR_PKT_LEN,
  parameter bit         SYNC_EN   = 1'b1,
  parameter logic [7:0] SYNC_BYTE = CORR_SYNC_BYTE,
  parameter int         SEQERR_W  = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_cg,
  input  logic                i_en,
  input  logic [7:0]          i_pktfifo_data,
  input  logic                i_pktfifo_empty,
  output logic                o_pktfifo_pop,
  output logic                o_pktfifo_flush,
  output logic [7:0]          o_txData,
  output logic                o_txValid,
  input  logic                i_txReady,
  output logic [SEQERR_W-1:0] o_seqErrors,
  input  logic                i_clrSeqErrors,
  output logic                o_busy
);

  localparam int                   IDX_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(PKT_LEN - 1);
  localparam logic [IDX_W-1:0]     IDX_WIN  = IDX_W'(PKT_IDX_WINNUM);
  localparam logic [SEQERR_W-1:0]  SEQ_MAX  = '1;

  strm_state_e          state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 tx_vld_q, tx_vld_d;
  logic [7:0]           tx_dat_q, tx_dat_d;
  logic [SEQERR_W-1:0]  seq_q, seq_d;
  logic [7:0]           exp_q, exp_d;
  logic                 first_q, first_d;
  logic                 en_q;

  logic en_rising;
  logic slot_free;
  logic pop;

  always_comb begin
    en_rising = i_en && !en_q;
    slot_free = !tx_vld_q || i_txReady;
    pop       = i_cg && !i_rst && !en_rising && (state_q == BODY) &&
                !i_pktfifo_empty && slot_free;

    state_d  = state_q;
    idx_d    = idx_q;
    tx_vld_d = tx_vld_q;
    tx_dat_d = tx_dat_q;
    seq_d    = seq_q;
    exp_d    = exp_q;
    first_d  = first_q;

    if (i_cg) begin
      if (tx_vld_q && i_txReady) tx_vld_d = 1'b0;

      // Re-enable restarts framing; a byte already in the slot still drains.
      if (en_rising) begin
        state_d = IDLE;
        idx_d   = '0;
        first_d = 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (i_en && !i_pktfifo_empty && slot_free) begin
              state_d = BODY;
              idx_d   = '0;
              if (SYNC_EN) begin
                tx_vld_d = 1'b1;
                tx_dat_d = SYNC_BYTE;
              end
            end
          end
          BODY: begin
            if (pop) begin
              tx_vld_d = 1'b1;
              tx_dat_d = i_pktfifo_data;
              if (idx_q == IDX_LAST) begin
                state_d = IDLE;
                idx_d   = '0;
              end else begin
                idx_d = idx_q + IDX_W'(1);
              end
              if (idx_q == IDX_WIN) begin
                exp_d   = i_pktfifo_data + 8'd1;
                first_d = 1'b0;
                if (!first_q && (i_pktfifo_data != exp_q) && (seq_q != SEQ_MAX))
                  seq_d = seq_q + SEQERR_W'(1);
              end
            end
          end
          default: state_d = IDLE;
        endcase
      end

      if (i_clrSeqErrors) seq_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      tx_vld_q <= 1'b0;
      tx_dat_q <= 8'h00;
      seq_q    <= '0;
      exp_q    <= 8'h00;
      first_q  <= 1'b1;
      en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      tx_vld_q <= tx_vld_d;
      tx_dat_q <= tx_dat_d;
      seq_q    <= seq_d;
      exp_q    <= exp_d;
      first_q  <= first_d;
      if (i_cg) en_q <= i_en;
    end
  end

  assign o_pktfifo_pop   = pop;
  assign o_pktfifo_flush = i_cg && !i_rst && en_rising;
  assign o_txData        = tx_dat_q;
  assign o_txValid       = tx_vld_q;
  assign o_seqErrors     = seq_q;
  assign o_busy          = (state_q != IDLE) || tx_vld_q;

endmodule

// File: tb/tb_corr_pkt_streamer.sv
// Scoreboard bench: stimulus pushes packets into a FIFO model and expected bytes into a queue;
// a negedge monitor pops and compares each accepted byte; sequence errors come from a packet-level model.
module tb_corr_pkt_streamer;
  import corr_pkg::*;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_cg = 1'b1;
  logic       i_en = 1'b0;
  logic [7:0] i_pktfifo_data = 8'h00;
  logic       i_pktfifo_empty = 1'b1;
  logic       o_pktfifo_pop, o_pktfifo_flush;
  logic [7:0] o_txData;
  logic       o_txValid;
  logic       i_txReady = 1'b1;
  logic [7:0] o_seqErrors;
  logic       i_clrSeqErrors = 1'b0;
  logic       o_busy;

  corr_pkt_streamer dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_cg(i_cg), .i_en(i_en),
    .i_pktfifo_data(i_pktfifo_data), .i_pktfifo_empty(i_pktfifo_empty),
    .o_pktfifo_pop(o_pktfifo_pop), .o_pktfifo_flush(o_pktfifo_flush),
    .o_txData(o_txData), .o_txValid(o_txValid), .i_txReady(i_txReady),
    .o_seqErrors(o_seqErrors), .i_clrSeqErrors(i_clrSeqErrors), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0, n_fail = 0;
  logic [7:0] fifo_q[$];
  bit         fifo_first[$];
  logic [7:0] exp_q[$];
  int  rdy_mode = 0, tog_ph = 0;
  bit  clr_req = 0, clr_armed = 0;
  int  flush_cnt = 0, cyc = 0, hs_first = -1, hs_last = -1;
  bit  prev_stall = 0;
  logic [7:0] prev_dat = 8'h00;
  // Packet-level sequence model
  bit   m_first = 1;
  logic [7:0] m_prev = 8'h00;
  int   m_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  task automatic refresh_fifo();
    i_pktfifo_empty = (fifo_q.size() == 0);
    i_pktfifo_data  = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
  endtask

  task automatic push_byte(input logic [7:0] d, input bit first);
    fifo_q.push_back(d);
    fifo_first.push_back(first);
    refresh_fifo();
  endtask

  task automatic model_pkt(input logic [39:0] p);
    logic [7:0] w;
    w = p[39:32];
    if (!m_first && w != m_prev + 8'd1 && m_err < 255) m_err++;
    m_prev  = w;
    m_first = 0;
    exp_q.push_back(CORR_SYNC_BYTE);
    for (int i = 0; i < 5; i++) exp_q.push_back(p[39-8*i -: 8]);
  endtask

  task automatic push_pkt(input logic [39:0] p);
    model_pkt(p);
    for (int i = 0; i < 5; i++) push_byte(p[39-8*i -: 8], i == 0);
  endtask

  function automatic logic [39:0] rnd_pkt(input logic [7:0] w);
    return {w, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
  endfunction

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0 || o_busy) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout: %0d bytes still expected after %0d cycles", exp_q.size(), budget);
    end
  endtask

  always @(posedge i_clk) cyc++;

  // FIFO model and host-ready driver
  always begin
    bit pop_s, flush_s;
    @(negedge i_clk);
    pop_s   = o_pktfifo_pop;
    flush_s = o_pktfifo_flush;
    if (flush_s) flush_cnt++;
    if (clr_req) begin
      i_clrSeqErrors = 1'b1;
      clr_req = 0;
    end else if (pop_s && clr_armed && fifo_first.size() > 0 && fifo_first[0]) begin
      i_clrSeqErrors = 1'b1;
      clr_armed = 0;
    end
    @(posedge i_clk); #1;
    i_clrSeqErrors = 1'b0;
    if (pop_s && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
      void'(fifo_first.pop_front());
    end
    if (flush_s) begin
      fifo_q.delete();
      fifo_first.delete();
    end
    case (rdy_mode)
      0: i_txReady = 1'b1;
      1: i_txReady = ($urandom_range(0, 9) < 7);
      2: begin i_txReady = (tog_ph == 0); tog_ph = (tog_ph + 1) % 3; end
      default: i_txReady = 1'b0;
    endcase
    refresh_fifo();
  end

  // Output monitor / scoreboard
  always @(negedge i_clk) begin
    if (i_rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", o_txValid, 1);
        check("stall_data_held", o_txData, prev_dat);
      end
      if (o_pktfifo_pop)
        check("pop_only_when_slot_free", (!o_txValid || i_txReady) && !i_pktfifo_empty && i_cg, 1);
      if (!i_cg) check("cg_no_pop_flush", {o_pktfifo_pop, o_pktfifo_flush}, 0);
      if (o_txValid && i_txReady) begin
        if (hs_first < 0) hs_first = cyc;
        hs_last = cyc;
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL tx_unexpected: got 0x%0h, expected no byte", o_txData);
        end else begin
          check("tx_byte", o_txData, exp_q.pop_front());
        end
      end
      prev_stall = o_txValid && !i_txReady;
      prev_dat   = o_txData;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fc;
    logic [39:0] p;
    logic [7:0]  w;

    // Reset state
    repeat (3) tick();
    @(negedge i_clk);
    check("rst_txValid", o_txValid, 0);
    check("rst_txData", o_txData, 0);
    check("rst_seqErrors", o_seqErrors, 0);
    check("rst_busy", o_busy, 0);
    check("rst_pop_flush", {o_pktfifo_pop, o_pktfifo_flush}, 0);

    // 1: enable -> single flush pulse, then a sync-prefixed packet at full rate
    tick();
    i_rst = 1'b0;
    i_en  = 1'b1;
    @(negedge i_clk);
    check("t1_flush_pulse", o_pktfifo_flush, 1);
    tick();
    @(negedge i_clk);
    check("t1_flush_once", o_pktfifo_flush, 0);
    tick();
    hs_first = -1;
    push_pkt(40'h03_10_20_30_40);
    wait_idle(50);
    check("t1_consecutive", hs_last - hs_first, 5);
    check("t1_busy_low", o_busy, 0);
    check("t1_seq", o_seqErrors, m_err);

    // 2: window discontinuity and 8-bit wrap
    push_pkt(rnd_pkt(8'h07));
    wait_idle(50);
    clr_req = 1;
    repeat (3) tick();
    m_err = 0;
    check("t2_cleared", o_seqErrors, 0);
    push_pkt(rnd_pkt(8'h09));
    wait_idle(50);
    check("t2_gap_counted", o_seqErrors, m_err);
    push_pkt(rnd_pkt(8'h0A));
    wait_idle(50);
    check("t2_continuous", o_seqErrors, m_err);
    push_pkt(rnd_pkt(8'hFF));
    push_pkt(rnd_pkt(8'h00));
    wait_idle(80);
    check("t2_wrap", o_seqErrors, m_err);

    // 3: host ready toggling 1,0,0 with back-to-back packets
    rdy_mode = 2;
    for (int i = 0; i < 3; i++) push_pkt(rnd_pkt(m_prev + 8'd1));
    wait_idle(200);
    rdy_mode = 0;
    check("t3_seq", o_seqErrors, m_err);

    // 4: FIFO runs dry after byte 2; BODY waits without re-inserting sync
    p = rnd_pkt(m_prev + 8'd1);
    model_pkt(p);
    for (int i = 0; i < 3; i++) push_byte(p[39-8*i -: 8], i == 0);
    repeat (10) tick();
    check("t4_busy_in_gap", o_busy, 1);
    check("t4_bytes_out", exp_q.size(), 2);
    for (int i = 3; i < 5; i++) push_byte(p[39-8*i -: 8], 1'b0);
    wait_idle(50);

    // 5: enable dropped mid-packet, re-raised later
    push_pkt(rnd_pkt(m_prev + 8'd1));
    for (int n = 0; n < 50 && exp_q.size() > 4; n++) tick();
    i_en = 1'b0;
    wait_idle(50);
    repeat (20) tick();
    check("t5_idle_while_off", o_busy, 0);
    fc = flush_cnt;
    i_en = 1'b1;
    m_first = 1;
    repeat (3) tick();
    check("t5_one_flush", flush_cnt, fc + 1);
    push_pkt(rnd_pkt(m_prev + 8'd77));
    wait_idle(50);
    check("t5_first_not_err", o_seqErrors, m_err);

    // Clock gate: everything frozen
    rdy_mode = 3;
    push_pkt(rnd_pkt(m_prev + 8'd1));
    repeat (4) tick();
    i_cg = 1'b0;
    repeat (6) tick();
    i_cg = 1'b1;
    rdy_mode = 0;
    wait_idle(50);

    // Random traffic
    rdy_mode = 1;
    for (int i = 0; i < 30; i++) begin
      w = ($urandom_range(0, 3) == 0) ? 8'($urandom) : m_prev + 8'd1;
      push_pkt(rnd_pkt(w));
      repeat ($urandom_range(0, 3)) tick();
    end
    wait_idle(1000);
    rdy_mode = 0;
    check("rand_seq", o_seqErrors, m_err);

    // 6: saturation, then clear coincident with an error
    for (int i = 0; i < 300; i++) push_pkt(rnd_pkt(m_prev + 8'd2));
    wait_idle(4000);
    check("t6_saturate", o_seqErrors, 255);
    check("t6_model_sat", o_seqErrors, m_err);
    clr_armed = 1;
    push_pkt(rnd_pkt(m_prev + 8'd2));
    m_err = 0;
    wait_idle(50);
    check("t6_clr_wins", o_seqErrors, 0);

    // Reset mid-packet
    push_pkt(rnd_pkt(m_prev + 8'd1));
    for (int n = 0; n < 50 && exp_q.size() > 3; n++) tick();
    rdy_mode = 3;
    repeat (2) tick();
    i_rst = 1'b1;
    tick();
    @(negedge i_clk);
    check("rstmid_txValid", o_txValid, 0);
    check("rstmid_busy", o_busy, 0);
    tick();
    fifo_q.delete();
    fifo_first.delete();
    exp_q.delete();
    refresh_fifo();
    m_err = 0; m_first = 1;
    fc = flush_cnt;
    i_rst = 1'b0;
    rdy_mode = 0;
    repeat (3) tick();
    check("rstmid_flush", flush_cnt, fc + 1);
    push_pkt(rnd_pkt(8'($urandom)));
    wait_idle(50);
    check("rstmid_seq", o_seqErrors, m_err);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
